// File: rtl/agex_mdu_if.sv
// ---------------------------------------------------------------------------
// agex_mdu_if
// Issue/result bundle between DE, the multiply/divide unit and the AGEX
// latch path.
//
// Issue side (DE -> MDU):
//   in_valid   DE presents an op
//   in_ready   MDU can accept an op this cycle
//   in_op      funct3 of the RV32M op
//   in_a/in_b  rs1 / rs2 values
//   in_tag     destination tag (rd number), carried through untouched
// Result side (MDU -> AGEX):
//   out_valid  result available
//   out_ready  consumer takes the result
//   out_result result value
//   out_tag    tag captured with the op
//
// master: the DE/AGEX side; slave: the MDU.
// ---------------------------------------------------------------------------
interface agex_mdu_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [XLEN-1:0]  in_a;
    logic [XLEN-1:0]  in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_op, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );
endinterface

// File: rtl/agex_mdu.sv
// ---------------------------------------------------------------------------
// agex_mdu
// Iterative RV32M multiply/divide unit running beside the AGEX ALU. One op in
// flight. Multiplies retire MUL_BITS multiplier bits per cycle (shift-add on
// magnitudes); divides are restoring, one quotient bit per cycle. A final
// fixup cycle applies signs and selects the result half.
//
// Ports:
//   clk    clock
//   reset  synchronous, active-high; overrides flush and any op in flight
//   flush  kills the in-flight op (and an untaken result); blocks accept
//   busy   state != IDLE, used by DE for hazard stall
//   bus    agex_mdu_if.slave: issue handshake in, result handshake out
//
// Latency from the accept edge: multiply XLEN/MUL_BITS+1, divide XLEN+1,
// divide special cases (b==0, MIN/-1) 1.
// ---------------------------------------------------------------------------
module agex_mdu #(
    parameter int XLEN     = 32,
    parameter int MUL_BITS = 2,
    parameter int TAG_W    = 5
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      flush,
    output logic      busy,
    agex_mdu_if.slave bus
);
    localparam int               CNT_W    = $clog2(XLEN + 1);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(XLEN / MUL_BITS);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(XLEN);
    localparam logic [XLEN-1:0]  X_MIN    = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0]  X_ONES   = {XLEN{1'b1}};

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_REM    = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } state_e;

    state_e state_q, state_d;

    logic [2:0]        op_q;
    logic [TAG_W-1:0]  tag_q;
    logic [XLEN-1:0]   result_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              neg_res_q;   // product / quotient must be negated
    logic              neg_rem_q;   // remainder takes the dividend sign
    logic              special_q;   // result preloaded at accept
    logic [2*XLEN-1:0] acc_q;       // product accumulator; low XLEN+1 bits hold the remainder on divide
    logic [2*XLEN-1:0] mcand_q;     // shifted multiplicand; low XLEN bits hold the divisor on divide
    logic [XLEN-1:0]   shreg_q;     // multiplier bits (mul) or dividend -> quotient (div)

    // ---------------- accept-time decode ----------------
    logic            accept;
    logic            div_signed_in;
    logic            a_neg_in, b_neg_in;
    logic [XLEN-1:0] a_mag_in, b_mag_in;
    logic            div_zero_in, div_ovf_in, special_in;
    logic [XLEN-1:0] special_val, acc_init_lo;

    assign bus.in_ready  = (state_q == ST_IDLE) && !flush;
    assign accept        = bus.in_valid && bus.in_ready;

    assign div_signed_in = (bus.in_op == F3_DIV) || (bus.in_op == F3_REM);
    assign a_neg_in      = (div_signed_in || bus.in_op == F3_MULH || bus.in_op == F3_MULHSU)
                           && bus.in_a[XLEN-1];
    assign b_neg_in      = (div_signed_in || bus.in_op == F3_MULH) && bus.in_b[XLEN-1];
    // Magnitudes fit XLEN unsigned bits, including |MIN| = 2^(XLEN-1).
    assign a_mag_in      = a_neg_in ? -bus.in_a : bus.in_a;
    assign b_mag_in      = b_neg_in ? -bus.in_b : bus.in_b;

    assign div_zero_in   = (bus.in_b == '0);
    assign div_ovf_in    = div_signed_in && (bus.in_a == X_MIN) && (bus.in_b == X_ONES);
    assign special_in    = bus.in_op[2] && (div_zero_in || div_ovf_in);

    // in_op[1] separates REM/REMU from DIV/DIVU.
    always_comb begin
        special_val = '0;
        if (div_zero_in) begin
            special_val = bus.in_op[1] ? bus.in_a : X_ONES;
        end else begin
            special_val = bus.in_op[1] ? '0 : X_MIN;
        end
    end

    assign acc_init_lo = special_in ? special_val : '0;

    // ---------------- iteration datapath ----------------
    logic [2*XLEN-1:0] mul_add;
    logic [2*XLEN-1:0] mul_prod;
    logic [XLEN:0]     div_shift, div_sub, div_rem_nxt;
    logic              div_ge;
    logic [XLEN-1:0]   div_q_fix, div_r_fix;

    always_comb begin
        mul_add = '0;
        for (int j = 0; j < MUL_BITS; j++) begin
            if (shreg_q[j]) begin
                mul_add = mul_add + (mcand_q << j);
            end
        end
    end

    assign mul_prod    = neg_res_q ? -acc_q : acc_q;

    // Partial remainder stays below the divisor, so bit XLEN of the
    // next remainder is always zero; it is kept only to keep widths uniform.
    assign div_shift   = {acc_q[XLEN-1:0], shreg_q[XLEN-1]};
    assign div_ge      = div_shift >= {1'b0, mcand_q[XLEN-1:0]};
    assign div_sub     = div_shift - {1'b0, mcand_q[XLEN-1:0]};
    assign div_rem_nxt = div_ge ? div_sub : div_shift;

    assign div_q_fix   = neg_res_q ? -shreg_q : shreg_q;
    assign div_r_fix   = neg_rem_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];

    // ---------------- FSM ----------------
    // NOTE: state and datapath registers use non-blocking assignments so
    // every register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept)                 state_d = bus.in_op[2] ? ST_DIV : ST_MUL;
            ST_MUL:  if (cnt_q == MUL_LAST)      state_d = ST_DONE;
            ST_DIV:  if (cnt_q == DIV_LAST)      state_d = ST_DONE;
            ST_DONE: if (bus.out_ready)          state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d = ST_IDLE;
        end
    end

    // Divide special cases enter ST_DIV with the count already at its last
    // value, so the next edge is the fixup cycle that publishes the
    // preloaded result: one cycle of latency without a separate path.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q      <= '0;
            tag_q     <= '0;
            result_q  <= '0;
            cnt_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            special_q <= 1'b0;
            acc_q     <= '0;
            mcand_q   <= '0;
            shreg_q   <= '0;
        end else if (accept) begin
            op_q      <= bus.in_op;
            tag_q     <= bus.in_tag;
            neg_res_q <= a_neg_in ^ b_neg_in;
            neg_rem_q <= a_neg_in;
            special_q <= special_in;
            cnt_q     <= special_in ? DIV_LAST : '0;
            acc_q     <= {{XLEN{1'b0}}, acc_init_lo};
            mcand_q   <= {{XLEN{1'b0}}, (bus.in_op[2] ? b_mag_in : a_mag_in)};
            shreg_q   <= bus.in_op[2] ? a_mag_in : b_mag_in;
        end else if (state_q == ST_MUL) begin
            if (cnt_q != MUL_LAST) begin
                acc_q   <= acc_q + mul_add;
                mcand_q <= mcand_q << MUL_BITS;
                shreg_q <= shreg_q >> MUL_BITS;
                cnt_q   <= cnt_q + CNT_W'(1);
            end else begin
                result_q <= (op_q == F3_MUL) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
            end
        end else if (state_q == ST_DIV) begin
            if (cnt_q != DIV_LAST) begin
                acc_q[XLEN:0] <= div_rem_nxt;
                shreg_q       <= {shreg_q[XLEN-2:0], div_ge};
                cnt_q         <= cnt_q + CNT_W'(1);
            end else if (special_q) begin
                result_q <= acc_q[XLEN-1:0];
            end else begin
                result_q <= op_q[1] ? div_r_fix : div_q_fix;
            end
        end
    end

    assign bus.out_valid  = (state_q == ST_DONE);
    assign bus.out_result = result_q;
    assign bus.out_tag    = tag_q;
    assign busy           = (state_q != ST_IDLE);
endmodule

// File: tb/tb_agex_mdu.sv
// ---------------------------------------------------------------------------
// tb_agex_mdu
// Directed bench for agex_mdu (XLEN=32, MUL_BITS=2, TAG_W=5). Expected
// results are pushed to a scoreboard queue at issue and popped when the unit
// raises out_valid. A behavioural reference model built on 64-bit arithmetic
// supplies expectations for the pseudo-random ops.
// ---------------------------------------------------------------------------
module tb_agex_mdu;
    localparam int XLEN  = 32;
    localparam int TAG_W = 5;

    localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
    localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

    typedef struct packed {
        logic [XLEN-1:0]  result;
        logic [TAG_W-1:0] tag;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic flush;
    logic busy;

    agex_mdu_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    agex_mdu #(.XLEN(XLEN), .MUL_BITS(2), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .busy  (busy),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t sb_q[$];

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [XLEN-1:0] ref_mdu(input logic [2:0] op, input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
        longint      sa, sb, ub, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'h0, b});
        p  = '0;
        case (op)
            MUL:     begin r = sa * sb; p = r; return p[31:0];  end
            MULH:    begin r = sa * sb; p = r; return p[63:32]; end
            MULHSU:  begin r = sa * ub; p = r; return p[63:32]; end
            MULHU:   begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
            DIV:     begin
                if (b == 0) return 32'hFFFF_FFFF;
                r = sa / sb; p = r; return p[31:0];
            end
            DIVU:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
            REM:     begin
                if (b == 0) return a;
                r = sa % sb; p = r; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] op, input logic [XLEN-1:0] a,
                                  input logic [XLEN-1:0] b);
        if (!op[2]) return 17;
        if (b == 0) return 1;
        if ((op == DIV || op == REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Presents one op for exactly one accept edge; optionally records the
    // expected result. Inputs are scrambled afterwards to prove they are
    // captured at accept.
    task automatic issue(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] exp, input bit push);
        int   n;
        exp_t e;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("in_ready_at_issue", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_tag   = tag;
        if (push) begin
            e.result = exp;
            e.tag    = tag;
            sb_q.push_back(e);
        end
        tick();
        bus.in_valid = 1'b0;
        bus.in_op    = 3'($urandom);
        bus.in_a     = $urandom;
        bus.in_b     = $urandom;
        bus.in_tag   = TAG_W'($urandom);
    endtask

    // Waits for out_valid, checks latency, stall outputs and the scoreboard
    // head. Leaves the bench sampling in the first out_valid cycle.
    task automatic wait_result(input int lat);
        int   n;
        bit   stall_ok;
        exp_t e;
        n        = 0;
        stall_ok = 1'b1;
        while (bus.out_valid !== 1'b1 && n < 200) begin
            if (bus.in_ready !== 1'b0 || busy !== 1'b1) stall_ok = 1'b0;
            tick();
            n++;
        end
        check("latency", n, lat);
        check("stall_while_busy", stall_ok, 1);
        if (sb_q.size() == 0) begin
            check("scoreboard_nonempty", 0, 1);
        end else begin
            e = sb_q.pop_front();
            check("out_result", bus.out_result, e.result);
            check("out_tag", bus.out_tag, e.tag);
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] exp, input int lat);
        issue(op, a, b, tag, exp, 1'b1);
        wait_result(lat);
        tick();
    endtask

    task automatic expect_quiet(input string name, input int cycles);
        bit saw;
        saw = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            if (bus.out_valid !== 1'b0) saw = 1'b1;
            tick();
        end
        check(name, saw, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]       op;
        logic [XLEN-1:0]  a, b, r_hold;
        logic [TAG_W-1:0] t_hold;
        bit               hold_ok;

        reset         = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_op     = '0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_result", bus.out_result, 0);
        check("rst_out_tag", bus.out_tag, 0);
        check("rst_busy", busy, 0);

        // Multiplies
        run_op(MUL,    32'd7,          32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, 17);
        run_op(MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 17);
        run_op(MULH,   32'h8000_0000,  32'h8000_0000, 5'd3, 32'h4000_0000, 17);
        run_op(MULHSU, 32'hFFFF_FFFF,  32'd2,         5'd4, 32'hFFFF_FFFF, 17);

        // Divides
        run_op(DIV,  32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, 33);
        run_op(REM,  32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 33);
        run_op(DIVU, 32'd100,       32'd7, 5'd7, 32'd14,        33);
        run_op(REMU, 32'd100,       32'd7, 5'd8, 32'd2,         33);

        // Divide special cases
        run_op(DIVU, 32'd5,         32'd0,         5'd9,  32'hFFFF_FFFF, 1);
        run_op(REM,  32'd5,         32'd0,         5'd10, 32'd5,         1);
        run_op(DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1);
        run_op(REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0,         1);

        // Pseudo-random ops against the reference model
        for (int i = 0; i < 10; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = (i % 4 == 3) ? 32'd0 : $urandom;
            if (i % 5 == 1) b = b >> 20;
            run_op(op, a, b, TAG_W'(13 + i), ref_mdu(op, a, b), lat_of(op, a, b));
        end

        // Backpressure: result held for 10 cycles with out_ready low
        bus.out_ready = 1'b0;
        issue(MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 5'd30,
              ref_mdu(MULHU, 32'h1234_5678, 32'h9ABC_DEF0), 1'b1);
        wait_result(17);
        r_hold  = bus.out_result;
        t_hold  = bus.out_tag;
        hold_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.out_valid !== 1'b1 || bus.out_result !== r_hold ||
                bus.out_tag !== t_hold || bus.in_ready !== 1'b0) hold_ok = 1'b0;
        end
        check("bp_hold_stable", hold_ok, 1);
        bus.out_ready = 1'b1;
        tick();
        check("bp_release_out_valid", bus.out_valid, 0);
        check("bp_release_in_ready", bus.in_ready, 1);

        // Flush in IDLE with an op presented: no accept
        bus.in_valid = 1'b1;
        bus.in_op    = DIVU;
        bus.in_a     = 32'd9;
        bus.in_b     = 32'd3;
        flush        = 1'b1;
        #1;
        check("idle_flush_in_ready", bus.in_ready, 0);
        tick();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        check("idle_flush_busy", busy, 0);
        expect_quiet("idle_flush_no_result", 40);

        // Flush at cycle 5 of a divide
        issue(DIV, 32'd1000, 32'd3, 5'd20, 32'd0, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("div_flush_busy", busy, 0);
        check("div_flush_out_valid", bus.out_valid, 0);
        expect_quiet("div_flush_no_result", 40);

        // Reset at cycle 8 of a multiply
        issue(MUL, 32'd12345, 32'd678, 5'd21, 32'd0, 1'b0);
        for (int i = 0; i < 7; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mul_reset_busy", busy, 0);
        check("mul_reset_out_result", bus.out_result, 0);
        check("mul_reset_out_tag", bus.out_tag, 0);
        expect_quiet("mul_reset_no_result", 25);

        // Next op after the aborts completes with its own tag
        run_op(MUL, 32'd12345, 32'd678, 5'd22, 32'd8369910, 17);

        // Flush while a result waits untaken in DONE
        bus.out_ready = 1'b0;
        issue(DIVU, 32'd5, 32'd0, 5'd23, 32'hFFFF_FFFF, 1'b1);
        wait_result(1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        bus.out_ready = 1'b1;
        check("done_flush_out_valid", bus.out_valid, 0);
        check("done_flush_busy", busy, 0);
        run_op(REMU, 32'd50, 32'd6, 5'd24, 32'd2, 33);

        check("scoreboard_drained", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
